// File: rtl/sprite_frame_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_seq_pkg: shared types and screen constants for the sprite frame   |
// | sequencer.                                      Revision: 1.0            |
// +--------------------------------------------------------------------------+
package sprite_seq_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      ERASE  = 3'd2,
      MOVE   = 3'd3,
      SETTLE = 3'd4,
      DRAW   = 3'd5,
      FINISH = 3'd6
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_frame_sequencer_if: sprite requests in, move pulses and the VGA   |
// | plot port out.                                  Revision: 1.0            |
// +--------------------------------------------------------------------------+
interface sprite_frame_sequencer_if #(
   parameter int NUM_SPRITES = 2
);
   logic                                           go;
   logic [NUM_SPRITES-1:0]                         req;
   logic [sprite_seq_pkg::X_W*NUM_SPRITES-1:0]     obj_x;
   logic [sprite_seq_pkg::Y_W*NUM_SPRITES-1:0]     obj_y;
   logic [sprite_seq_pkg::COLOUR_W*NUM_SPRITES-1:0] obj_colour;
   logic [NUM_SPRITES-1:0]                         move_en;
   logic [NUM_SPRITES-1:0]                         grant;
   logic [sprite_seq_pkg::X_W-1:0]                 vga_x;
   logic [sprite_seq_pkg::Y_W-1:0]                 vga_y;
   logic [sprite_seq_pkg::COLOUR_W-1:0]            vga_colour;
   logic                                           vga_plot;
   logic                                           busy;
   logic                                           frame_done;

   // The sequencer is the master: it owns the plot port and the move pulses.
   modport master (
      input  go, req, obj_x, obj_y, obj_colour,
      output move_en, grant, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
   );

   modport slave (
      output go, req, obj_x, obj_y, obj_colour,
      input  move_en, grant, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/sprite_frame_sequencer_rect_pixel_walker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rect_pixel_walker: row-major SPRITE_W x SPRITE_H pixel walk, one pixel   |
// | per cycle. Clipping when SPRITE_SEQ_CLIP_EN is defined. Revision: 1.0    |
// +--------------------------------------------------------------------------+
module rect_pixel_walker
   import sprite_seq_pkg::*;
#(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 2
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start_i,
   input  logic [X_W-1:0] base_x_i,
   input  logic [Y_W-1:0] base_y_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           active_o,
   output logic           last_o
);
   localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             run_q, run_d;
   logic             col_end, row_end;

   assign col_end = (col_q == COL_LAST);
   assign row_end = (row_q == ROW_LAST);
   assign last_o  = run_q & col_end & row_end;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      run_d = run_q;
      if (start_i) begin
         col_d = '0;
         row_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (col_end) begin
            col_d = '0;
            if (row_end) begin
               run_d = 1'b0;
            end else begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_q <= '0;
         row_q <= '0;
         run_q <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         run_q <= run_d;
      end
   end

`ifdef SPRITE_SEQ_CLIP_EN
   // One extra bit so off-screen pixels are detected before truncation.
   localparam int XS_W = X_W + 1;
   localparam int YS_W = Y_W + 1;

   logic [XS_W-1:0] sum_x;
   logic [YS_W-1:0] sum_y;

   assign sum_x    = {1'b0, base_x_i} + XS_W'(col_q);
   assign sum_y    = {1'b0, base_y_i} + YS_W'(row_q);
   assign x_o      = sum_x[X_W-1:0];
   assign y_o      = sum_y[Y_W-1:0];
   assign active_o = run_q & (sum_x < XS_W'(SCREEN_W)) & (sum_y < YS_W'(SCREEN_H));
`else
   assign x_o      = base_x_i + X_W'(col_q);
   assign y_o      = base_y_i + Y_W'(row_q);
   assign active_o = run_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sprite_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_frame_sequencer: once per frame erases, moves and redraws each    |
// | requesting sprite over one shared VGA plot port. Optional clipping:      |
// | SPRITE_SEQ_CLIP_EN.                             Revision: 1.0            |
// +--------------------------------------------------------------------------+
module sprite_frame_sequencer
   import sprite_seq_pkg::*;
#(
   parameter int NUM_SPRITES = 2,
   parameter int SPRITE_W    = 16,
   parameter int SPRITE_H    = 2,
   parameter int FRAME_DIV   = 833333
) (
   input  logic                     clk,
   input  logic                     resetn,
   sprite_frame_sequencer_if.master bus
);
   localparam int PTR_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int FDIV_W = $clog2(FRAME_DIV);
   localparam logic [FDIV_W-1:0] FDIV_RELOAD = FDIV_W'(FRAME_DIV - 1);
   localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(NUM_SPRITES - 1);

   seq_state_e state_q, state_d;

   logic [FDIV_W-1:0]      cnt_q;
   logic                   tick;
   logic                   pending_q, pending_clr;
   logic                   empty_done_q, empty_done_d;
   logic [NUM_SPRITES-1:0] serve_q, serve_d;
   logic [PTR_W-1:0]       rr_q, rr_d;
   logic [PTR_W-1:0]       cur_q, cur_d;
   logic [PTR_W-1:0]       pick, scan;
   logic                   found;
   logic                   walk_start, walk_last, walk_active, latch_pos;
   logic [X_W-1:0]         walk_x;
   logic [Y_W-1:0]         walk_y;

   logic [NUM_SPRITES-1:0] valid_q;
   logic [X_W-1:0]         pos_x_q   [NUM_SPRITES];
   logic [Y_W-1:0]         pos_y_q   [NUM_SPRITES];
   logic [COLOUR_W-1:0]    pos_col_q [NUM_SPRITES];

   logic [X_W-1:0]         obj_x_w   [NUM_SPRITES];
   logic [Y_W-1:0]         obj_y_w   [NUM_SPRITES];
   logic [COLOUR_W-1:0]    obj_col_w [NUM_SPRITES];

   logic [X_W-1:0]         vga_x_q;
   logic [Y_W-1:0]         vga_y_q;
   logic [COLOUR_W-1:0]    vga_colour_q;
   logic                   vga_plot_q;

   logic [NUM_SPRITES-1:0] grant, move_en;

   for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_unpack
      assign obj_x_w[gi]   = bus.obj_x[X_W*gi +: X_W];
      assign obj_y_w[gi]   = bus.obj_y[Y_W*gi +: Y_W];
      assign obj_col_w[gi] = bus.obj_colour[COLOUR_W*gi +: COLOUR_W];
   end

   // Free-running frame timer; a tick is latched 1-deep, extra ticks are lost.
   assign tick = (cnt_q == '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q     <= FDIV_RELOAD;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= tick ? FDIV_RELOAD : cnt_q - FDIV_W'(1);
         pending_q <= tick | (pending_q & ~pending_clr);
      end
   end

   // Round-robin pick: first set serve bit at or after rr_q, wrapping.
   always_comb begin
      pick  = rr_q;
      found = 1'b0;
      scan  = rr_q;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (!found && serve_q[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
         scan = (scan == PTR_LAST) ? '0 : scan + PTR_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      serve_d      = serve_q;
      rr_d         = rr_q;
      cur_d        = cur_q;
      pending_clr  = 1'b0;
      empty_done_d = 1'b0;
      walk_start   = 1'b0;
      latch_pos    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pending_q && bus.go) begin
               pending_clr = 1'b1;
               serve_d     = bus.req;
               if (bus.req == '0) begin
                  empty_done_d = 1'b1;
               end else begin
                  state_d = SELECT;
               end
            end
         end
         SELECT: begin
            if (found) begin
               serve_d[pick] = 1'b0;
               cur_d         = pick;
               // Nothing has been drawn yet for this sprite: no erase pass.
               if (valid_q[pick]) begin
                  walk_start = 1'b1;
                  state_d    = ERASE;
               end else begin
                  state_d = MOVE;
               end
            end else begin
               state_d = FINISH;
            end
         end
         ERASE: begin
            if (walk_last) state_d = MOVE;
         end
         MOVE: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            latch_pos  = 1'b1;
            walk_start = 1'b1;
            state_d    = DRAW;
         end
         DRAW: begin
            if (walk_last) state_d = SELECT;
         end
         FINISH: begin
            rr_d    = (rr_q == PTR_LAST) ? '0 : rr_q + PTR_W'(1);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         serve_q      <= '0;
         rr_q         <= '0;
         cur_q        <= '0;
         empty_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         serve_q      <= serve_d;
         rr_q         <= rr_d;
         cur_q        <= cur_d;
         empty_done_q <= empty_done_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x_q[i]   <= '0;
            pos_y_q[i]   <= '0;
            pos_col_q[i] <= '0;
         end
      end else if (latch_pos) begin
         valid_q[cur_q]   <= 1'b1;
         pos_x_q[cur_q]   <= obj_x_w[cur_q];
         pos_y_q[cur_q]   <= obj_y_w[cur_q];
         pos_col_q[cur_q] <= obj_col_w[cur_q];
      end
   end

   rect_pixel_walker #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
   ) u_walker (
      .clk      (clk),
      .resetn   (resetn),
      .start_i  (walk_start),
      .base_x_i (pos_x_q[cur_q]),
      .base_y_i (pos_y_q[cur_q]),
      .x_o      (walk_x),
      .y_o      (walk_y),
      .active_o (walk_active),
      .last_o   (walk_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         vga_x_q      <= walk_x;
         vga_y_q      <= walk_y;
         vga_colour_q <= (state_q == DRAW) ? pos_col_q[cur_q] : '0;
         vga_plot_q   <= walk_active & ((state_q == ERASE) || (state_q == DRAW));
      end
   end

   always_comb begin
      grant   = '0;
      move_en = '0;
      if (state_q == SELECT) begin
         if (found) grant[pick] = 1'b1;
      end else if (state_q inside {ERASE, MOVE, SETTLE, DRAW}) begin
         grant[cur_q] = 1'b1;
      end
      if (state_q == MOVE) move_en[cur_q] = 1'b1;
   end

   assign bus.grant      = grant;
   assign bus.move_en    = move_en;
   assign bus.busy       = state_q inside {SELECT, ERASE, MOVE, SETTLE, DRAW};
   assign bus.frame_done = (state_q == FINISH) | empty_done_q;
   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_colour = vga_colour_q;
   assign bus.vga_plot   = vga_plot_q;

endmodule
`default_nettype wire

// File: doc/sprite_frame_sequencer.md
Name: sprite_frame_sequencer

Overview:
- Frame-rate controller that shares the single 160x120 VGA plot port among NUM_SPRITES rectangular sprites (paddles, ball).
- Once per frame, for each requesting sprite in turn: erase its last-drawn rectangle, pulse that sprite's move enable, then draw it at its new position.
- Replaces the per-object erase/move/draw FSMs and ad-hoc delay counters; sits between the sprite position datapaths and vga_adapter.

Parameters:
- NUM_SPRITES, 2, number of requesters (1..4).
- SPRITE_W, 16, rectangle width in pixels (1..16).
- SPRITE_H, 2, rectangle height in pixels (1..8).
- FRAME_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- go  in  1  run enable; when low, no new frame starts.
- req  in  NUM_SPRITES  sprite i wants service this frame.
- obj_x  in  8*NUM_SPRITES  sprite i top-left x, slice [8i+7:8i].
- obj_y  in  7*NUM_SPRITES  sprite i top-left y, slice [7i+6:7i].
- obj_colour  in  3*NUM_SPRITES  sprite i draw colour.
- move_en  out  NUM_SPRITES  one-cycle pulse telling sprite i to update its position.
- grant  out  NUM_SPRITES  one-hot; sprite currently being serviced.
- vga_x  out  8  plot x.
- vga_y  out  7  plot y.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  write strobe, one pixel per cycle.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0; state IDLE; frame counter = FRAME_DIV-1; rr_ptr = 0; per-sprite valid bits and stored positions cleared.
- Frame timer: down-counter, always running; tick on the cycle it reaches 0, then reloads to FRAME_DIV-1.
- Pending tick: a tick sets a 1-deep pending flag. Ticks arriving while the flag is already set are dropped.
- Frame start: in IDLE with pending set and go=1:
  - clear pending; snapshot req into serve_mask; busy=1.
  - if serve_mask==0, pulse frame_done immediately and return to IDLE.
- State sequence: IDLE -> SELECT -> ERASE -> MOVE -> SETTLE -> DRAW -> SELECT ... -> FINISH -> IDLE.
- SELECT (1 cycle):
  - pick the lowest index >= rr_ptr, wrapping modulo NUM_SPRITES, with serve_mask bit set.
  - assert grant for it and clear its serve_mask bit.
  - if none remain, go to FINISH.
- ERASE:
  - if the valid bit is 0, skip directly to MOVE.
  - otherwise walk the stored rectangle row-major: col 0..SPRITE_W-1 within row 0..SPRITE_H-1, one pixel per cycle; colour 3'b000; vga_plot=1 (see clipping). Lasts SPRITE_W*SPRITE_H cycles.
- MOVE: move_en[g]=1 for exactly one cycle.
- SETTLE: one cycle with no plot, then sample obj_x/obj_y/obj_colour[g] into the stored registers and set valid[g].
- DRAW: same walk as ERASE at the stored position with the stored colour.
- FINISH: frame_done=1 and busy=0 for one cycle; rr_ptr = (rr_ptr+1) mod NUM_SPRITES; go to IDLE.
- Pixel coordinates: vga_x = base_x + col truncated to 8 bits; vga_y = base_y + row truncated to 7 bits. vga_x/vga_y/vga_colour are registered together with vga_plot.
- req changes mid-frame are ignored until the next frame start.
- go falling mid-frame: the current frame completes; only the next frame start is blocked. The pending flag is retained.
- Async reset mid-frame: immediate return to reset values. The next frame performs no erase for any sprite.
- grant stays asserted from SELECT through the last DRAW cycle of that sprite.

Optional Feature:
- Macro SPRITE_SEQ_CLIP_EN.
- Defined: a pixel with base_x+col > 159 or base_y+row > 119 (computed at 9/8 bits, no truncation) has vga_plot=0. Cycle count is unchanged.
- Undefined: no clipping; truncated coordinates are emitted with vga_plot=1 for every pixel.

Decomposition:
- Package sprite_seq_pkg holds:
  - state enum (IDLE, SELECT, ERASE, MOVE, SETTLE, DRAW, FINISH);
  - SCREEN_W=160, SCREEN_H=120;
  - X_W=8, Y_W=7, COLOUR_W=3.
- Sub-module rect_pixel_walker: inputs start, base_x, base_y; outputs x, y, active, last. It owns the col/row counters and clip compare, and is reused for both ERASE and DRAW.

Test Plan:
- Reset with FRAME_DIV=16, NUM_SPRITES=2, SPRITE_W=4, SPRITE_H=1, req=01, sprite0 at (50,60) colour 7 -> first frame: no erase; move_en[0] pulse; plots (50..53,60) colour 7; frame_done one cycle later.
- Second frame with sprite0 position now (51,60) -> erase plots (50..53,60) colour 0, then move_en[0], then draw (51..54,60) colour 7.
- req=11 over two frames -> frame A order sprite0 then sprite1; frame B order sprite1 then sprite0; grant stays one-hot throughout.
- Sprite at (158,60), SPRITE_W=4 -> with SPRITE_SEQ_CLIP_EN plot high only for x=158,159; without it plot high for x=158,159,160,161.
- Hold go=0 across three ticks, then set go=1 -> exactly one frame runs; remaining ticks are dropped; busy spans the whole frame.
- Assert resetn low during DRAW of sprite1 -> all outputs 0 immediately; next frame shows no erase plots for either sprite.
